// File: rtl/riscv_chk_pkg.sv
// rtl/riscv_chk_pkg.sv - shared encodings and types for the RISC-V execute-path scoreboard
package riscv_chk_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BTYPE = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SUB  = 3'b001;
    localparam logic [2:0] F3_OR   = 3'b010;
    localparam logic [2:0] F3_AND  = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SUBI = 3'b001;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b010;
    localparam logic [2:0] F3_BGT  = 3'b011;

    typedef enum logic {K_ALU, K_BR} kind_e;

    typedef enum logic [1:0] {IDLE, WAIT, TMO} state_e;

    // Expected result value is kept in a separate XLEN-wide array beside this entry.
    typedef struct packed {
        logic [31:0] instr;
        kind_e       kind;
        logic        exp_zero;
        logic        exp_bt;
    } exp_entry_t;

endpackage

// File: rtl/riscv_golden_alu.sv
// rtl/riscv_golden_alu.sv - combinational golden model of the supported ALU/branch subset
module riscv_golden_alu
    import riscv_chk_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            legal_o,
    output kind_e           kind_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            bt_o
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic            unused_bits;

    assign opcode      = instr_i[6:0];
    assign funct3      = instr_i[14:12];
    assign imm         = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign unused_bits = ^{instr_i[19:15], instr_i[11:7]};

    // Branches report the taken bit as their result so a failure capture shows it directly.
    always_comb begin
        legal_o  = 1'b1;
        kind_o   = K_ALU;
        result_o = '0;
        bt_o     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct3)
                    F3_ADD:  result_o = rs1_i + rs2_i;
                    F3_SUB:  result_o = rs1_i - rs2_i;
                    F3_OR:   result_o = rs1_i | rs2_i;
                    F3_AND:  result_o = rs1_i & rs2_i;
                    F3_XOR:  result_o = rs1_i ^ rs2_i;
                    default: legal_o  = 1'b0;
                endcase
            end
            OP_ITYPE: begin
                case (funct3)
                    F3_ADDI: result_o = rs1_i + imm;
                    F3_SUBI: result_o = rs1_i - imm;
                    default: legal_o  = 1'b0;
                endcase
            end
            OP_BTYPE: begin
                kind_o = K_BR;
                case (funct3)
                    F3_BEQ:  bt_o    = (rs1_i == rs2_i);
                    F3_BNE:  bt_o    = (rs1_i != rs2_i);
                    F3_BLT:  bt_o    = ($signed(rs1_i) < $signed(rs2_i));
                    F3_BGT:  bt_o    = ($signed(rs1_i) > $signed(rs2_i));
                    default: legal_o = 1'b0;
                endcase
                result_o = {{(XLEN-1){1'b0}}, bt_o};
            end
            default: legal_o = 1'b0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/riscv_alu_scoreboard.sv
// rtl/riscv_alu_scoreboard.sv - in-order expectation queue and checker for the RISC-V execute path
module riscv_alu_scoreboard
    import riscv_chk_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     iss_valid,
    output logic                     iss_ready,
    input  logic [31:0]              iss_instr,
    input  logic [XLEN-1:0]          iss_rs1_val,
    input  logic [XLEN-1:0]          iss_rs2_val,
    input  logic                     res_valid,
    input  logic [XLEN-1:0]          alu_result,
    input  logic                     zero_flag,
    input  logic                     bt,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic [CNT_W-1:0]         orphan_cnt,
    output logic [CNT_W-1:0]         illegal_cnt,
    output logic                     err,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              ff_instr,
    output logic [XLEN-1:0]          ff_exp,
    output logic [XLEN-1:0]          ff_got
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [WW-1:0] TMO_C  = WW'(TIMEOUT);

    exp_entry_t      meta_q [DEPTH];
    logic [XLEN-1:0] res_q  [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    state_e          state_q, state_d;

    logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q, orphan_cnt_q, illegal_cnt_q;
    logic             err_q, ff_valid_q;
    logic [31:0]      ff_instr_q;
    logic [XLEN-1:0]  ff_exp_q, ff_got_q;

    logic            g_legal, g_zero, g_bt;
    kind_e           g_kind;
    logic [XLEN-1:0] g_result;

    logic            empty, full, push, pop, match;
    logic            illegal_ev, orphan_ev, pass_ev, fail_ev;
    exp_entry_t      head_meta;
    logic [XLEN-1:0] head_res, got_val;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    riscv_golden_alu #(.XLEN(XLEN)) u_golden (
        .instr_i  (iss_instr),
        .rs1_i    (iss_rs1_val),
        .rs2_i    (iss_rs2_val),
        .legal_o  (g_legal),
        .kind_o   (g_kind),
        .result_o (g_result),
        .zero_o   (g_zero),
        .bt_o     (g_bt)
    );

    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_C);
    assign iss_ready  = !full;
    assign push       = iss_valid && !full && g_legal;
    assign illegal_ev = iss_valid && !full && !g_legal;
    // Pop looks only at the registered occupancy, so a same-cycle push never bypasses.
    assign pop        = res_valid && !empty;
    assign orphan_ev  = res_valid && empty;

    assign head_meta = meta_q[rd_ptr_q];
    assign head_res  = res_q[rd_ptr_q];
    assign got_val   = (head_meta.kind == K_BR) ? {{(XLEN-1){1'b0}}, bt} : alu_result;

    always_comb begin
        if (head_meta.kind == K_BR) begin
            match = (bt == head_meta.exp_bt);
        end else begin
            match = (alu_result == head_res) && (zero_flag == head_meta.exp_zero);
        end
    end

    assign pass_ev = pop && match;
    assign fail_ev = pop && !match;

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        wdog_d = wdog_q;
        if (res_valid || empty) begin
            wdog_d = '0;
        end else if (state_q == WAIT) begin
            wdog_d = wdog_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            meta_q[wr_ptr_q] <= '{instr: iss_instr, kind: g_kind, exp_zero: g_zero, exp_bt: g_bt};
            res_q[wr_ptr_q]  <= g_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wdog_q        <= '0;
            pass_cnt_q    <= '0;
            fail_cnt_q    <= '0;
            orphan_cnt_q  <= '0;
            illegal_cnt_q <= '0;
            err_q         <= 1'b0;
            ff_valid_q    <= 1'b0;
            ff_instr_q    <= '0;
            ff_exp_q      <= '0;
            ff_got_q      <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q       <= count_d;
            wdog_q        <= wdog_d;
            pass_cnt_q    <= sat_inc(pass_cnt_q, pass_ev);
            fail_cnt_q    <= sat_inc(fail_cnt_q, fail_ev);
            orphan_cnt_q  <= sat_inc(orphan_cnt_q, orphan_ev);
            illegal_cnt_q <= sat_inc(illegal_cnt_q, illegal_ev);
            err_q         <= err_q | fail_ev | orphan_ev | (state_d == TMO);
            if (fail_ev && !ff_valid_q) begin
                ff_valid_q <= 1'b1;
                ff_instr_q <= head_meta.instr;
                ff_exp_q   <= head_res;
                ff_got_q   <= got_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (push) state_d = WAIT;
            WAIT: begin
                if (wdog_d == TMO_C) begin
                    state_d = TMO;
                end else if (count_d == '0) begin
                    state_d = IDLE;
                end
            end
            TMO:     state_d = TMO;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        timeout = (state_q == TMO);
    end

    assign pass_cnt    = pass_cnt_q;
    assign fail_cnt    = fail_cnt_q;
    assign orphan_cnt  = orphan_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
    assign err         = err_q;
    assign occupancy   = count_q;
    assign ff_instr    = ff_instr_q;
    assign ff_exp      = ff_exp_q;
    assign ff_got      = ff_got_q;

endmodule

// File: tb/tb_riscv_alu_scoreboard.sv
// tb/tb_riscv_alu_scoreboard.sv - randomized and directed bench for riscv_alu_scoreboard
module tb_riscv_alu_scoreboard;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset, clr, iss_valid, res_valid, zero_flag, bt, iss_ready;
    logic [31:0]      iss_instr, iss_rs1_val, iss_rs2_val, alu_result;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, orphan_cnt, illegal_cnt;
    logic             err, timeout;
    logic [3:0]       occupancy;
    logic [31:0]      ff_instr, ff_exp, ff_got;

    always #5 clk = ~clk;

    riscv_alu_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_instr(iss_instr),
        .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val),
        .res_valid(res_valid), .alu_result(alu_result), .zero_flag(zero_flag), .bt(bt),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .orphan_cnt(orphan_cnt), .illegal_cnt(illegal_cnt),
        .err(err), .timeout(timeout), .occupancy(occupancy),
        .ff_instr(ff_instr), .ff_exp(ff_exp), .ff_got(ff_got)
    );

    typedef struct {
        logic [31:0] instr;
        bit          br;
        logic [31:0] res;
        bit          taken;
    } exp_t;

    exp_t        mq[$];
    int          m_pass, m_fail, m_orph, m_ill, m_idle;
    bit          m_err, m_tmo, m_ffv;
    logic [31:0] m_ffi, m_ffe, m_ffg;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                      output bit legal, output bit br, output logic [31:0] res,
                                      output bit taken);
        int          sa, sb;
        logic [31:0] imm;
        sa    = a;
        sb    = b;
        imm   = {{20{ins[31]}}, ins[31:20]};
        legal = 1;
        br    = 0;
        res   = 0;
        taken = 0;
        case (ins[6:0])
            7'b0110011: case (ins[14:12])
                3'd0: res = a + b;
                3'd1: res = a - b;
                3'd2: res = a | b;
                3'd3: res = a & b;
                3'd4: res = a ^ b;
                default: legal = 0;
            endcase
            7'b0010011: case (ins[14:12])
                3'd0: res = a + imm;
                3'd1: res = a - imm;
                default: legal = 0;
            endcase
            7'b1100011: begin
                br = 1;
                case (ins[14:12])
                    3'd0: taken = (a == b);
                    3'd1: taken = (a != b);
                    3'd2: taken = (sa < sb);
                    3'd3: taken = (sa > sb);
                    default: legal = 0;
                endcase
                res = {31'b0, taken};
            end
            default: legal = 0;
        endcase
    endfunction

    function automatic void m_clear();
        mq.delete();
        m_pass = 0; m_fail = 0; m_orph = 0; m_ill = 0; m_idle = 0;
        m_err = 0; m_tmo = 0; m_ffv = 0;
        m_ffi = 0; m_ffe = 0; m_ffg = 0;
    endfunction

    // Apply the current inputs to the model, clock the DUT, then compare every output.
    task automatic cycle();
        exp_t        h;
        bit          lg, br, tk, hit;
        logic [31:0] r;
        int          pre;
        pre = mq.size();
        if (!reset || clr) begin
            m_clear();
        end else begin
            ref_model(iss_instr, iss_rs1_val, iss_rs2_val, lg, br, r, tk);
            if (res_valid && pre > 0) begin
                h   = mq.pop_front();
                hit = h.br ? (bt == h.taken) : ((alu_result == h.res) && (zero_flag == (h.res == 0)));
                if (hit) begin
                    m_pass++;
                end else begin
                    m_fail++;
                    m_err = 1;
                    if (!m_ffv) begin
                        m_ffv = 1;
                        m_ffi = h.instr;
                        m_ffe = h.res;
                        m_ffg = h.br ? {31'b0, bt} : alu_result;
                    end
                end
            end else if (res_valid) begin
                m_orph++;
                m_err = 1;
            end
            if (iss_valid && pre < DEPTH) begin
                if (lg) mq.push_back('{instr: iss_instr, br: br, res: r, taken: tk});
                else    m_ill++;
            end
            if (!m_tmo) begin
                if (res_valid || pre == 0) m_idle = 0;
                else                       m_idle++;
                if (m_idle >= TIMEOUT) begin
                    m_tmo = 1;
                    m_err = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("occupancy", occupancy, mq.size());
        check("iss_ready", iss_ready, mq.size() < DEPTH);
        check("pass_cnt", pass_cnt, m_pass);
        check("fail_cnt", fail_cnt, m_fail);
        check("orphan_cnt", orphan_cnt, m_orph);
        check("illegal_cnt", illegal_cnt, m_ill);
        check("err", err, m_err);
        check("timeout", timeout, m_tmo);
        check("ff_instr", ff_instr, m_ffi);
        check("ff_exp", ff_exp, m_ffe);
        check("ff_got", ff_got, m_ffg);
    endtask

    task automatic idle_inputs();
        reset = 1; clr = 0; iss_valid = 0; res_valid = 0;
        iss_instr = 0; iss_rs1_val = 0; iss_rs2_val = 0;
        alu_result = 0; zero_flag = 0; bt = 0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        iss_valid = 1; iss_instr = ins; iss_rs1_val = a; iss_rs2_val = b;
        cycle();
        iss_valid = 0;
    endtask

    task automatic result(input logic [31:0] v, input logic z, input logic t);
        res_valid = 1; alu_result = v; zero_flag = z; bt = t;
        cycle();
        res_valid = 0;
    endtask

    task automatic do_clr();
        clr = 1;
        cycle();
        clr = 0;
    endtask

    localparam logic [31:0] I_ADD  = {7'b0, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
    localparam logic [31:0] I_SUB  = {7'b0, 5'd3, 5'd2, 3'b001, 5'd1, 7'b0110011};
    localparam logic [31:0] I_BLT  = {7'b0, 5'd3, 5'd2, 3'b010, 5'd0, 7'b1100011};
    localparam logic [31:0] I_ADDI = {12'hFFF, 5'd2, 3'b000, 5'd1, 7'b0010011};
    localparam logic [31:0] I_LOAD = {12'h004, 5'd2, 3'b010, 5'd1, 7'b0000011};

    initial begin
        logic [6:0]  ops [4];
        logic [31:0] ins, v;
        m_clear();
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b1100011; ops[3] = 7'b0000011;
        idle_inputs();

        reset = 0;
        cycle();
        cycle();
        reset = 1;
        check("rst_occ", occupancy, 0);
        check("rst_ready", iss_ready, 1);
        check("rst_err", err, 0);

        issue(I_ADD, 32'd5, 32'd3);
        cycle();
        cycle();
        result(32'd8, 1'b0, 1'b0);
        check("add_pass", pass_cnt, 1);
        issue(I_SUB, 32'd3, 32'd5);
        result(32'hFFFF_FFFE, 1'b0, 1'b0);
        check("sub_pass", pass_cnt, 2);

        issue(I_BLT, 32'hFFFF_FFFF, 32'd1);
        result(32'd0, 1'b0, 1'b0);
        check("blt_fail", fail_cnt, 1);
        check("blt_err", err, 1);
        check("blt_ffexp", ff_exp, 1);
        check("blt_ffgot", ff_got, 0);

        do_clr();
        for (int i = 0; i < DEPTH; i++) issue(I_ADDI, 32'd0, 32'd0);
        check("full_ready", iss_ready, 0);
        check("full_occ", occupancy, 8);
        issue(I_ADDI, 32'd0, 32'd0);
        check("drop_occ", occupancy, 8);
        for (int i = 0; i < DEPTH; i++) result(32'hFFFF_FFFF, 1'b0, 1'b0);
        check("drain_pass", pass_cnt, 8);
        check("drain_occ", occupancy, 0);

        do_clr();
        result(32'd0, 1'b1, 1'b0);
        check("orphan_cnt1", orphan_cnt, 1);
        check("orphan_err", err, 1);
        issue(I_LOAD, 32'd1, 32'd2);
        check("illegal_cnt1", illegal_cnt, 1);
        check("illegal_occ", occupancy, 0);

        do_clr();
        issue(I_ADD, 32'd1, 32'd1);
        for (int i = 0; i < TIMEOUT - 1; i++) cycle();
        check("tmo_early", timeout, 0);
        cycle();
        check("tmo_hit", timeout, 1);
        check("tmo_err", err, 1);
        do_clr();
        check("tmo_clr", timeout, 0);
        check("tmo_clr_occ", occupancy, 0);

        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            if ($urandom_range(0, 99) < 2) clr = 1;
            if ($urandom_range(0, 99) < 55) begin
                ins = $urandom;
                ins[6:0]   = ops[$urandom_range(0, 3)];
                ins[14:12] = 3'($urandom_range(0, 5));
                iss_valid   = 1;
                iss_instr   = ins;
                iss_rs1_val = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
                iss_rs2_val = ($urandom_range(0, 3) == 0) ? iss_rs1_val : $urandom;
            end
            if ($urandom_range(0, 99) < 45) begin
                res_valid = 1;
                if (mq.size() > 0) begin
                    v          = mq[0].res;
                    alu_result = v;
                    zero_flag  = (v == 0);
                    bt         = mq[0].taken;
                    if ($urandom_range(0, 99) < 20) begin
                        case ($urandom_range(0, 2))
                            0:       alu_result = v ^ (32'd1 << $urandom_range(0, 31));
                            1:       zero_flag  = ~zero_flag;
                            default: bt         = ~bt;
                        endcase
                    end
                end else begin
                    alu_result = $urandom;
                end
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
